// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry.
// Used by both uart_rx and uart_tx.
package uart_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle level (1).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver. Define UART_RX_PARITY_EN to add an even-parity
// bit between the data bits and the stop bit, with an o_parity_err strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_done,
    output logic                 o_rx_busy,
`ifdef UART_RX_PARITY_EN
    output logic                 o_parity_err,
`endif
    output logic                 o_frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_done_q;
    logic                 rx_busy_q;
    logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                 parity_q;
    logic                 parity_err_q;
`endif
    logic                 rx_s;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_done_q    <= 1'b0;
            rx_busy_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: strobes default low every clock so each one lasts exactly one cycle.
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (baud_tick) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_s) begin
                            state_q    <= START;
                            tick_cnt_q <= '0;
                            rx_busy_q  <= 1'b1;
                        end
                    end

                    START: begin
                        // A start bit still low at mid-bit is genuine; otherwise it was a glitch.
                        if (tick_cnt_q == TICK_MID) begin
                            tick_cnt_q <= '0;
                            if (!rx_s) begin
                                state_q   <= DATA;
                                bit_cnt_q <= '0;
                            end else begin
                                state_q   <= IDLE;
                                rx_busy_q <= 1'b0;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end

                    DATA: begin
                        if (tick_cnt_q == TICK_LAST) begin
                            shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (tick_cnt_q == TICK_LAST) begin
                            parity_q   <= rx_s;
                            tick_cnt_q <= '0;
                            state_q    <= STOP;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
`endif

                    STOP: begin
                        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
                        if (tick_cnt_q == TICK_LAST) begin
                            rx_data_q   <= shift_q;
                            tick_cnt_q  <= '0;
                            state_q     <= IDLE;
                            rx_busy_q   <= 1'b0;
                            frame_err_q <= !rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= ^{shift_q, parity_q};
                            rx_done_q    <= rx_s && !(^{shift_q, parity_q});
`else
                            rx_done_q   <= rx_s;
`endif
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end

                    default: begin
                        state_q   <= IDLE;
                        rx_busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rx_data   = rx_data_q;
    assign o_rx_done   = rx_done_q;
    assign o_rx_busy   = rx_busy_q;
    assign o_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial driver pushes expected results, a monitor
// pops and compares whenever the receiver raises a strobe.
module tb_uart_rx;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_DIV   = 4;
    localparam int BIT_CLK    = OVERSAMPLE * TICK_DIV;

    typedef enum logic [1:0] {K_DONE, K_FERR, K_PERR} kind_e;
    typedef struct {
        kind_e      kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] o_rx_data;
    logic       o_rx_done;
    logic       o_rx_busy;
    logic       o_frame_err;
    logic       perr;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   tick_div_cnt = 0;
    exp_t sb[$];
    int   done_cyc[$];

    uart_rx #(.OVERSAMPLE(OVERSAMPLE), .DATA_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .rx          (rx),
        .o_rx_data   (o_rx_data),
        .o_rx_done   (o_rx_done),
        .o_rx_busy   (o_rx_busy),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(perr),
`endif
        .o_frame_err (o_frame_err)
    );

`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tick_div_cnt == TICK_DIV - 1) begin
            tick_div_cnt = 0;
            baud_tick = 1'b1;
        end else begin
            tick_div_cnt++;
            baud_tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        kind_e k;
        if (!rst && (o_rx_done || o_frame_err || perr)) begin
            check("strobe_exclusive", 32'(o_rx_done & o_frame_err), 0);
            check("busy_low_at_strobe", 32'(o_rx_busy), 0);
            check("strobe_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                k = perr ? K_PERR : (o_frame_err ? K_FERR : K_DONE);
                check("strobe_kind", 32'(k), 32'(e.kind));
                check("rx_data", 32'(o_rx_data), 32'(e.data));
            end
            if (o_rx_done) done_cyc.push_back(cyc);
        end
    end

    task automatic drive_bit(input logic v, input bit do_abort);
        rx = v;
        if (do_abort) begin
            repeat (BIT_CLK / 2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_data_reset", 32'(o_rx_data), 0);
            check("abort_busy_reset", 32'(o_rx_busy), 0);
            repeat (BIT_CLK / 2 - 1) @(negedge clk);
        end else begin
            repeat (BIT_CLK) @(negedge clk);
        end
    endtask

    // par < 0: no parity bit; otherwise the parity bit value to send.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int abort_bit, input int par);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i], abort_bit == i);
        if (par >= 0) drive_bit(par[0], 1'b0);
        drive_bit(stop_bit, 1'b0);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4 * BIT_CLK; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check(name, 32'(sb.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        int diff;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("reset_data", 32'(o_rx_data), 0);
        check("reset_done", 32'(o_rx_done), 0);
        check("reset_busy", 32'(o_rx_busy), 0);
        check("reset_ferr", 32'(o_frame_err), 0);
        idle_bits(2);

        // Plain frame 0x30.
        sb.push_back('{K_DONE, 8'h30});
        send_frame(8'h30, 1'b1, -1, -1);
        idle_bits(1);
        wait_drain("drain_0x30");

        // Three-tick low glitch: busy pulses, no strobe.
        rx = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_rx_busy) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("glitch_busy_rise", 32'(seen), 1);
        seen = 1'b0;
        for (int i = 0; i < 3 * OVERSAMPLE * TICK_DIV; i++) begin
            if (!o_rx_busy) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("glitch_busy_fall", 32'(seen), 1);
        idle_bits(1);

        // Stop bit forced low: frame error carrying 0xA5.
        sb.push_back('{K_FERR, 8'hA5});
        send_frame(8'hA5, 1'b0, -1, -1);
        idle_bits(2);
        wait_drain("drain_0xA5_ferr");
        check("ferr_data_held", 32'(o_rx_data), 32'h A5);

        // Back-to-back frames, no idle between them: 10 bit-times apart.
        done_cyc.delete();
        sb.push_back('{K_DONE, 8'h55});
        sb.push_back('{K_DONE, 8'hAA});
        send_frame(8'h55, 1'b1, -1, -1);
        send_frame(8'hAA, 1'b1, -1, -1);
        idle_bits(1);
        wait_drain("drain_b2b");
        check("b2b_done_count", 32'(done_cyc.size()), 2);
        if (done_cyc.size() == 2) begin
            diff = done_cyc[1] - done_cyc[0];
            check("b2b_spacing", 32'(diff >= 10 * BIT_CLK - TICK_DIV && diff <= 10 * BIT_CLK + TICK_DIV), 1);
        end

        // Reset during bit 4 of 0xFF aborts silently; 0x0F then arrives intact.
        send_frame(8'hFF, 1'b1, 4, -1);
        idle_bits(1);
        sb.push_back('{K_DONE, 8'h0F});
        send_frame(8'h0F, 1'b1, -1, -1);
        idle_bits(1);
        wait_drain("drain_0x0F");
        check("post_abort_data", 32'(o_rx_data), 32'h0F);

`ifdef UART_RX_PARITY_EN
        sb.push_back('{K_DONE, 8'h03});
        send_frame(8'h03, 1'b1, -1, 0);
        idle_bits(1);
        wait_drain("drain_par_ok");
        sb.push_back('{K_PERR, 8'h03});
        send_frame(8'h03, 1'b1, -1, 1);
        idle_bits(1);
        wait_drain("drain_par_err");
`endif

        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; downstream partner of uart_tx, consuming its serial line.
- Samples the line using an oversampled tick from a baudrate generator instance configured for BAUD×OVERSAMPLE.
- Delivers each received byte with a 1-clk done strobe, a busy flag and a frame-error strobe.
- Standard loopback: uart_tx.o_tx → uart_rx.rx.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; even, ≥4.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous, active-high reset
- baud_tick  input  1  1-clk pulse at BAUD×OVERSAMPLE rate
- rx  input  1  asynchronous serial line, idle high
- o_rx_data  output  DATA_BITS  last received byte
- o_rx_done  output  1  1-clk pulse, o_rx_data valid and good
- o_rx_busy  output  1  high from start detection until return to IDLE
- o_frame_err  output  1  1-clk pulse, stop bit sampled 0

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, tick_cnt=0, bit_cnt=0, shift=0, o_rx_data=0, o_rx_done=0, o_rx_busy=0, o_frame_err=0, synchronizer flops=1.
- The rx line passes through a 2-FF synchronizer (rx_s) before any use; this adds 2 clk of latency.
- All counting advances only on clocks where baud_tick=1.
- States:
  - IDLE: on baud_tick with rx_s=0 → START, tick_cnt=0, o_rx_busy=1.
  - START: on tick, tick_cnt++. When tick_cnt==OVERSAMPLE/2-1, sample rx_s.
    - If 0: → DATA, tick_cnt=0, bit_cnt=0.
    - If 1 (glitch): → IDLE, busy=0, no strobes.
  - DATA: on tick, tick_cnt++. When tick_cnt==OVERSAMPLE-1: shift={rx_s, shift[DATA_BITS-1:1]}, tick_cnt=0, bit_cnt++. After DATA_BITS samples → STOP (or PARITY, see optional feature).
  - STOP: when tick_cnt==OVERSAMPLE-1, sample rx_s.
    - If 1: o_rx_data<=shift, o_rx_done=1 for one clk.
    - If 0: o_rx_data<=shift, o_frame_err=1 for one clk, o_rx_done stays 0.
    - Either way → IDLE, busy=0 on the same clk.
- Each sample is taken at mid-bit. Leaving STOP at mid-stop-bit allows a back-to-back start bit to be caught with no lost frame.
- o_rx_data holds its value until the next completed frame.
- o_rx_done and o_frame_err are never high together.
- rst asserted mid-frame aborts the frame: no strobe, outputs go to reset values on the next posedge.
- A line held low continuously: the frame completes with frame_err, then the receiver re-enters START from IDLE on the next tick (break condition; no lockup).
- baud_tick is never required on consecutive clocks.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit.
  - Extra output port o_parity_err (1 bit): a 1-clk pulse at the STOP sample when ^{shift,parity}!=0.
  - On a parity error, o_rx_done is suppressed and o_rx_data is still updated.
  - Frame = 11 bits.
- Undefined: the PARITY state and the port do not exist; frame = 10 bits (8N1).

Decomposition:
- Package uart_pkg:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP), shared with uart_tx;
  - DATA_BITS_DEF=8 and OVERSAMPLE_DEF=16 constants.
- One sub-module, uart_rx_sync: a 2-FF synchronizer with reset value 1.

Test Plan:
- Loopback with uart_tx, din=8'h30, baudrate at 9600×16 from a 100 MHz clk, start pulse at t=40 ns → one o_rx_done pulse, o_rx_data=8'h30, o_frame_err=0, busy falls on the done clk.
- 3-tick-wide low glitch on idle rx → START entered, returns to IDLE at the mid sample; no done or frame_err; busy pulses only.
- Frame 8'hA5 with stop bit forced 0 → o_frame_err one clk, o_rx_data=8'hA5, no o_rx_done.
- Back-to-back 8'h55 then 8'hAA with zero idle bits → two done pulses, in order, ~10 bit-times apart.
- rst high for 1 clk during bit 4 of 8'hFF → all outputs reset, no strobe; the following frame 8'h0F is received correctly.
- With UART_RX_PARITY_EN: 8'h03 with parity=0 → done; same byte with parity=1 → o_parity_err, no done.
